oled_pwr_seq_core: RTL and testbench

// - Slot-bus core driving PmodOLED control pins; successor to the 4-bit OLED GPIO slot.
// - Adds a hardware power-up/down sequencer with programmable inter-step delay.
// - Adds AUX_W general-purpose outputs and readback of all registers plus sequencer status.
// - Sits in an MMIO slot beside the SPI core that streams OLED data/commands.

---
 rtl/oled_pwr_seq_core.sv | 197 +++++++++++++++++++
 tb/tb_oled_pwr_seq_core.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_pwr_seq_core.sv
// PmodOLED slot core: DC/AUX pins, register readback and a timed VDD/RST/VBAT power sequencer.
// Optional build macro OLED_SEQ_IRQ_EN adds the sequence-done interrupt and its pending register.
//   state    | meaning
//   OFF      | panel unpowered, idle
//   VDD_ON   | logic supply enabled, reset released
//   RST_LO   | reset pulse asserted
//   RST_HI   | reset released, waiting before VBAT
//   VBAT_ON  | panel supply enabled, settling
//   ON       | fully powered, idle
//   VBAT_OFF | panel supply removed
//   VDD_OFF  | logic supply removed, settling
module oled_pwr_seq_core #(
  parameter int              CNT_W         = 24,
  parameter logic [CNT_W-1:0] DEFAULT_DELAY = 24'd100000,
  parameter int              AUX_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              read,
  input  logic              write,
  input  logic [4:0]        addr,
  input  logic [31:0]       wr_data,
  output logic [31:0]       rd_data,
  output logic              oled_dc,
  output logic              oled_reset,
  output logic              oled_vbatc,
  output logic              oled_vddc,
  output logic [AUX_W-1:0]  aux_out,
  output logic              irq
);

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_VDD_ON   = 3'd1,
    ST_RST_LO   = 3'd2,
    ST_RST_HI   = 3'd3,
    ST_VBAT_ON  = 3'd4,
    ST_ON       = 3'd5,
    ST_VBAT_OFF = 3'd6,
    ST_VDD_OFF  = 3'd7
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [CNT_W-1:0]  delay_reg;
  logic [CNT_W-1:0]  delay_load;
  logic [2:0]        reg_addr;
  logic              wr_en;
  logic              start_up;
  logic              start_down;
  logic              busy;
  logic              powered;
  logic              vddc_next, vbatc_next, res_next;
  logic              unused_inputs;

  assign reg_addr   = addr[2:0];
  assign wr_en      = cs && write;
  assign start_up   = wr_en && (reg_addr == 3'd1) && wr_data[0];
  assign start_down = wr_en && (reg_addr == 3'd1) && wr_data[1];
  assign busy       = (state != ST_OFF) && (state != ST_ON);
  assign powered    = (state == ST_ON);
  assign unused_inputs = ^{read, addr[4:3], wr_data};

  // A programmed delay of 0 behaves as 1; the counter runs from load down to 0.
  assign delay_load = (delay_reg == '0) ? '0 : delay_reg - CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oled_dc   <= 1'b0;
      aux_out   <= '0;
      delay_reg <= DEFAULT_DELAY;
    end else if (wr_en) begin
      case (reg_addr)
        3'd0:    oled_dc   <= wr_data[0];
        3'd2:    delay_reg <= wr_data[CNT_W-1:0];
        3'd4:    aux_out   <= wr_data[AUX_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_OFF;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_OFF: begin
        if (start_up) begin
          state_next = ST_VDD_ON;
          cnt_next   = delay_load;
        end
      end
      ST_ON: begin
        if (start_down) begin
          state_next = ST_VBAT_OFF;
          cnt_next   = delay_load;
        end
      end
      default: begin
        if (cnt != '0) begin
          cnt_next = cnt - CNT_W'(1);
        end else begin
          cnt_next = delay_load;
          case (state)
            ST_VDD_ON:   state_next = ST_RST_LO;
            ST_RST_LO:   state_next = ST_RST_HI;
            ST_RST_HI:   state_next = ST_VBAT_ON;
            ST_VBAT_ON:  state_next = ST_ON;
            ST_VBAT_OFF: state_next = ST_VDD_OFF;
            ST_VDD_OFF:  state_next = ST_OFF;
            default:     state_next = ST_OFF;
          endcase
          if ((state_next == ST_ON) || (state_next == ST_OFF)) begin
            cnt_next = '0;
          end
        end
      end
    endcase
  end

  // Pin levels are decoded from the next state so the flops change with the transition.
  always_comb begin
    vddc_next  = 1'b1;
    vbatc_next = 1'b1;
    res_next   = 1'b0;
    case (state_next)
      ST_OFF:      begin vddc_next = 1'b1; vbatc_next = 1'b1; res_next = 1'b0; end
      ST_VDD_ON:   begin vddc_next = 1'b0; vbatc_next = 1'b1; res_next = 1'b1; end
      ST_RST_LO:   begin vddc_next = 1'b0; vbatc_next = 1'b1; res_next = 1'b0; end
      ST_RST_HI:   begin vddc_next = 1'b0; vbatc_next = 1'b1; res_next = 1'b1; end
      ST_VBAT_ON:  begin vddc_next = 1'b0; vbatc_next = 1'b0; res_next = 1'b1; end
      ST_ON:       begin vddc_next = 1'b0; vbatc_next = 1'b0; res_next = 1'b1; end
      ST_VBAT_OFF: begin vddc_next = 1'b0; vbatc_next = 1'b1; res_next = 1'b1; end
      ST_VDD_OFF:  begin vddc_next = 1'b1; vbatc_next = 1'b1; res_next = 1'b1; end
      default:     begin vddc_next = 1'b1; vbatc_next = 1'b1; res_next = 1'b0; end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oled_vddc  <= 1'b1;
      oled_vbatc <= 1'b1;
      oled_reset <= 1'b0;
    end else begin
      oled_vddc  <= vddc_next;
      oled_vbatc <= vbatc_next;
      oled_reset <= res_next;
    end
  end

`ifdef OLED_SEQ_IRQ_EN
  logic irq_pending;
  logic seq_done;

  assign seq_done = busy && ((state_next == ST_ON) || (state_next == ST_OFF));

  // Completion has priority over a clear landing in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= 1'b0;
    end else if (seq_done) begin
      irq_pending <= 1'b1;
    end else if (wr_en && (reg_addr == 3'd5)) begin
      irq_pending <= 1'b0;
    end
  end

  assign irq = irq_pending;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (reg_addr)
      3'd0: rd_data[0]         = oled_dc;
      3'd2: rd_data[CNT_W-1:0] = delay_reg;
      3'd3: rd_data[6:0]       = {state, 2'b00, powered, busy};
      3'd4: rd_data[AUX_W-1:0] = aux_out;
`ifdef OLED_SEQ_IRQ_EN
      3'd5: rd_data[0]         = irq_pending;
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oled_pwr_seq_core.sv
// Self-checking bench for oled_pwr_seq_core: directed sequencing scenarios plus randomized
// up/down sequences with spurious bus traffic, checked against a step-timeline model.
module tb_oled_pwr_seq_core;
  localparam int          CNT_W = 24;
  localparam int          AUX_W = 4;
  localparam logic [23:0] DEF   = 24'd100000;
`ifdef OLED_SEQ_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  logic             clk, reset, cs, read, write;
  logic [4:0]       addr;
  logic [31:0]      wr_data, rd_data;
  logic             oled_dc, oled_reset, oled_vbatc, oled_vddc, irq;
  logic [AUX_W-1:0] aux_out;

  int errors = 0;
  int checks = 0;

  // Pin levels per state code (bit index = state code), from the power table.
  logic [7:0] vddc_tab  = 8'b1000_0001;
  logic [7:0] vbatc_tab = 8'b1100_1111;
  logic [7:0] res_tab   = 8'b1111_1010;

  logic             exp_dc;
  logic [AUX_W-1:0] exp_aux;

  oled_pwr_seq_core #(.CNT_W(CNT_W), .DEFAULT_DELAY(DEF), .AUX_W(AUX_W)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .oled_dc(oled_dc), .oled_reset(oled_reset),
    .oled_vbatc(oled_vbatc), .oled_vddc(oled_vddc), .aux_out(aux_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Power-up: first step lasts e1 cycles, the remaining three e2 each, then ON.
  function automatic int up_code(input int k, input int e1, input int e2);
    int s;
    if (k < e1) return 1;
    s = 2 + (k - e1) / e2;
    return (s > 5) ? 5 : s;
  endfunction

  function automatic int down_code(input int k, input int e);
    if (k < e) return 6;
    if (k < 2 * e) return 7;
    return 0;
  endfunction

  function automatic logic [31:0] exp_status(input int code);
    logic [31:0] s;
    s = 32'(code) << 4;
    if (code == 5) s = s | 32'h2;
    if (code != 0 && code != 5) s = s | 32'h1;
    return s;
  endfunction

  function automatic logic [2:0] pins_of(input int code);
    return {vddc_tab[code], vbatc_tab[code], res_tab[code]};
  endfunction

  function automatic int eff_of(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cs = 1'b0;
    write = 1'b0;
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    step();
  endtask

  task automatic read_reg(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rd_data;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_dc = 1'b0;
    exp_aux = '0;
    step();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++;
    if ({oled_vddc, oled_vbatc, oled_reset} !== 3'b110) begin
      errors++; $display("FAIL reset_pins got=%b exp=110", {oled_vddc, oled_vbatc, oled_reset});
    end
    checks++;
    if ({oled_dc, aux_out, irq} !== 6'b0) begin
      errors++; $display("FAIL reset_dc_aux_irq got=%b exp=000000", {oled_dc, aux_out, irq});
    end
    read_reg(5'd2, d);
    checks++;
    if (d !== 32'(DEF)) begin errors++; $display("FAIL reset_delay got=%h exp=%h", d, 32'(DEF)); end
    read_reg(5'd3, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reset_status got=%h exp=0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d;
    bus_write(5'd0, 32'h3);
    bus_write(5'd4, 32'hFFFF_FFFA);
    read_reg(5'd0, d);
    checks++;
    if (oled_dc !== 1'b1 || d !== 32'h1) begin
      errors++; $display("FAIL dc_reg got=%b/%h exp=1/1", oled_dc, d);
    end
    read_reg(5'd4, d);
    checks++;
    if (aux_out !== 4'hA || d !== 32'hA) begin
      errors++; $display("FAIL aux_reg got=%h/%h exp=a/a", aux_out, d);
    end
    bus_write(5'd2, 32'hFFFF_FFFF);
    read_reg(5'd2, d);
    checks++;
    if (d !== 32'h00FF_FFFF) begin errors++; $display("FAIL delay_width got=%h exp=00ffffff", d); end
    bus_write(5'd6, 32'hDEAD_BEEF);
    read_reg(5'd6, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL reserved_read got=%h exp=0", d); end
    bus_write(5'd1, 32'h0);
    read_reg(5'd1, d);
    checks++;
    if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read got=%h exp=0", d); end
    bus_write(5'd8, 32'h0);
    checks++;
    if (oled_dc !== 1'b0) begin errors++; $display("FAIL addr_alias got=%b exp=0", oled_dc); end
    bus_write(5'd5, 32'h1);
    read_reg(5'd5, d);
    checks++;
    if (d !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL irq_idle got=%h/%b exp=0/0", d, irq);
    end
  endtask

  task automatic test_power_up();
    logic [31:0] st;
    int code;
    do_reset();
    bus_write(5'd2, 32'd10);
    bus_write(5'd1, 32'h1);
    for (int k = 0; k <= 42; k++) begin
      code = up_code(k, 10, 10);
      read_reg(5'd3, st);
      checks++;
      if ({oled_vddc, oled_vbatc, oled_reset} !== pins_of(code)) begin
        errors++;
        $display("FAIL up_pins k=%0d got=%b exp=%b", k, {oled_vddc, oled_vbatc, oled_reset}, pins_of(code));
      end
      checks++;
      if (st !== exp_status(code)) begin
        errors++; $display("FAIL up_status k=%0d got=%h exp=%h", k, st, exp_status(code));
      end
      step();
    end
    checks++;
    if (irq !== IRQ_EN) begin errors++; $display("FAIL up_irq got=%b exp=%b", irq, IRQ_EN); end
  endtask

  task automatic test_power_down();
    logic [31:0] st;
    int code;
    bus_write(5'd5, 32'h0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq); end
    bus_write(5'd2, 32'd5);
    bus_write(5'd1, 32'h2);
    for (int k = 0; k <= 12; k++) begin
      code = down_code(k, 5);
      read_reg(5'd3, st);
      checks++;
      if ({oled_vddc, oled_vbatc, oled_reset} !== pins_of(code)) begin
        errors++;
        $display("FAIL down_pins k=%0d got=%b exp=%b", k, {oled_vddc, oled_vbatc, oled_reset}, pins_of(code));
      end
      checks++;
      if (st !== exp_status(code)) begin
        errors++; $display("FAIL down_status k=%0d got=%h exp=%h", k, st, exp_status(code));
      end
      step();
    end
    checks++;
    if (irq !== IRQ_EN) begin errors++; $display("FAIL down_irq got=%b exp=%b", irq, IRQ_EN); end
  endtask

  task automatic test_ignored_starts();
    logic [31:0] st;
    int code;
    bus_write(5'd1, 32'h2);
    for (int k = 0; k < 3; k++) begin
      read_reg(5'd3, st);
      checks++;
      if (st !== 32'h0) begin errors++; $display("FAIL down_in_off k=%0d got=%h exp=0", k, st); end
      step();
    end
    bus_write(5'd2, 32'd10);
    bus_write(5'd1, 32'h1);
    for (int k = 0; k <= 42; k++) begin
      code = up_code(k, 10, 10);
      read_reg(5'd3, st);
      checks++;
      if (st !== exp_status(code) || {oled_vddc, oled_vbatc, oled_reset} !== pins_of(code)) begin
        errors++; $display("FAIL busy_start k=%0d got=%h exp=%h", k, st, exp_status(code));
      end
      @(negedge clk);
      if (k == 12 || k == 25) begin
        cs = 1'b1; write = 1'b1; addr = 5'd1; wr_data = (k == 12) ? 32'h1 : 32'h3;
      end
      step();
    end
    bus_write(5'd1, 32'h1);
    for (int k = 0; k < 3; k++) begin
      read_reg(5'd3, st);
      checks++;
      if (st !== 32'h52) begin errors++; $display("FAIL up_in_on k=%0d got=%h exp=52", k, st); end
      step();
    end
  endtask

  task automatic test_zero_delay();
    logic [31:0] st;
    int code;
    do_reset();
    bus_write(5'd2, 32'd0);
    bus_write(5'd1, 32'h1);
    for (int k = 0; k <= 6; k++) begin
      code = up_code(k, 1, 1);
      read_reg(5'd3, st);
      checks++;
      if (st !== exp_status(code) || {oled_vddc, oled_vbatc, oled_reset} !== pins_of(code)) begin
        errors++; $display("FAIL zero_delay k=%0d got=%h exp=%h", k, st, exp_status(code));
      end
      step();
    end
    // Clear write lands on the edge that enters ON.
    do_reset();
    bus_write(5'd2, 32'd0);
    bus_write(5'd1, 32'h1);
    step(); step(); step();
    bus_write(5'd5, 32'h0);
    read_reg(5'd3, st);
    checks++;
    if (st !== 32'h52 || irq !== IRQ_EN) begin
      errors++; $display("FAIL irq_set_wins got=%h/%b exp=52/%b", st, irq, IRQ_EN);
    end
    bus_write(5'd5, 32'h0);
    read_reg(5'd5, st);
    checks++;
    if (irq !== 1'b0 || st !== 32'h0) begin
      errors++; $display("FAIL irq_clear2 got=%b/%h exp=0/0", irq, st);
    end
  endtask

  task automatic test_mid_delay_write();
    logic [31:0] st;
    int code;
    do_reset();
    bus_write(5'd2, 32'd10);
    bus_write(5'd1, 32'h1);
    for (int k = 0; k <= 22; k++) begin
      code = up_code(k, 10, 3);
      read_reg(5'd3, st);
      checks++;
      if (st !== exp_status(code)) begin
        errors++; $display("FAIL mid_delay k=%0d got=%h exp=%h", k, st, exp_status(code));
      end
      @(negedge clk);
      if (k == 3) begin
        cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'd3;
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] st;
    do_reset();
    bus_write(5'd2, 32'd10);
    bus_write(5'd1, 32'h1);
    for (int k = 0; k < 33; k++) step();
    checks++;
    if ({oled_vddc, oled_vbatc, oled_reset} !== 3'b001) begin
      errors++; $display("FAIL vbat_on_pins got=%b exp=001", {oled_vddc, oled_vbatc, oled_reset});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({oled_vddc, oled_vbatc, oled_reset} !== 3'b110) begin
      errors++; $display("FAIL async_reset_pins got=%b exp=110", {oled_vddc, oled_vbatc, oled_reset});
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    read_reg(5'd3, st);
    checks++;
    if (st !== 32'h0) begin errors++; $display("FAIL status_after_reset got=%h exp=0", st); end
    read_reg(5'd2, st);
    checks++;
    if (st !== 32'(DEF)) begin errors++; $display("FAIL delay_after_reset got=%h exp=%h", st, 32'(DEF)); end
  endtask

  task automatic test_random();
    logic [31:0] st, rv;
    int code, e, limit, kind;
    logic upd_dc, upd_aux;
    logic [31:0] upd_val;
    for (int it = 0; it < 15; it++) begin
      do_reset();
      rv = $urandom;
      bus_write(5'd0, rv);
      exp_dc = rv[0];
      rv = $urandom;
      bus_write(5'd4, rv);
      exp_aux = rv[AUX_W-1:0];
      for (int ph = 0; ph < 2; ph++) begin
        e = eff_of(int'($urandom_range(0, 12)));
        bus_write(5'd2, (e == 1 && $urandom_range(0, 1) == 1) ? 32'd0 : 32'(e));
        if (ph == 0) bus_write(5'd1, ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h1);
        else         bus_write(5'd1, ($urandom_range(0, 1) == 1) ? 32'h3 : 32'h2);
        limit = (ph == 0) ? 4 * e : 2 * e;
        for (int k = 0; k <= limit + 1; k++) begin
          code = (ph == 0) ? up_code(k, e, e) : down_code(k, e);
          read_reg(5'd3, st);
          checks++;
          if ({oled_vddc, oled_vbatc, oled_reset, oled_dc, aux_out} !== {pins_of(code), exp_dc, exp_aux}) begin
            errors++;
            $display("FAIL rand_pins it=%0d ph=%0d k=%0d got=%b exp=%b", it, ph, k,
                     {oled_vddc, oled_vbatc, oled_reset, oled_dc, aux_out}, {pins_of(code), exp_dc, exp_aux});
          end
          checks++;
          if (st !== exp_status(code)) begin
            errors++; $display("FAIL rand_status it=%0d ph=%0d k=%0d got=%h exp=%h", it, ph, k, st, exp_status(code));
          end
          upd_dc = 1'b0;
          upd_aux = 1'b0;
          upd_val = $urandom;
          @(negedge clk);
          if (k < limit && $urandom_range(0, 3) == 0) begin
            kind = int'($urandom_range(0, 2));
            cs = 1'b1; write = 1'b1;
            case (kind)
              0: begin addr = 5'd1; wr_data = 32'($urandom_range(1, 3)); end
              1: begin addr = 5'd0; wr_data = upd_val; upd_dc = 1'b1; end
              default: begin addr = 5'd4; wr_data = upd_val; upd_aux = 1'b1; end
            endcase
          end
          step();
          if (upd_dc) exp_dc = upd_val[0];
          if (upd_aux) exp_aux = upd_val[AUX_W-1:0];
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; read = 1'b0; write = 1'b0; addr = '0; wr_data = '0;
    exp_dc = 1'b0; exp_aux = '0;
    test_reset();
    test_regs();
    test_power_up();
    test_power_down();
    test_ignored_starts();
    test_zero_delay();
    test_mid_delay_write();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
